cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer.sv | 156 +++++++++++++++
 tb/tb_cpu_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
//------------------------------------------------------------------------------
// cpu_sequencer
// Multi-cycle CPU control sequencer: FETCH/DECODE/EXEC/MEM/WB with halt,
// memory-wait timeout to a terminal bus-error state and a retire counter.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module cpu_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        haltReq,
  input  logic        isLoad,
  input  logic        isStore,
  input  logic        regsWEnDec,
  input  logic        memReady,
  output logic        irWEn,
  output logic        pcWEn,
  output logic        regsWEn,
  output logic        ramReq,
  output logic        ramWrite,
  output logic [2:0]  state,
  output logic        busy,
  output logic        halted,
  output logic        busErr,
  output logic [31:0] instRetired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  // Counter value seen on the last permitted MEM cycle (counter holds the
  // number of MEM cycles already spent before the current one).
  localparam logic [7:0] C_LAST_WAIT = 8'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        load_q, load_d;
  logic        store_q, store_d;
  logic        wen_q, wen_d;
  logic [7:0]  waitCnt_q, waitCnt_d;
  logic [31:0] retired_q, retired_d;

  // Next-state, class latch, wait counter and retire counter
  always_comb begin
    state_d   = state_q;
    load_d    = load_q;
    store_d   = store_q;
    wen_d     = wen_q;
    waitCnt_d = waitCnt_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        load_d  = isLoad;
        store_d = isStore;
        wen_d   = regsWEnDec;
        state_d = (isLoad && isStore) ? S_ERR : S_EXEC;
      end
      S_EXEC: begin
        // Clearing here means the counter is zero on the first MEM cycle.
        waitCnt_d = 8'd0;
        state_d   = (load_q || store_q) ? S_MEM : S_WB;
      end
      S_MEM: begin
        waitCnt_d = waitCnt_q + 8'd1;
        if (memReady)                       state_d = S_WB;
        else if (waitCnt_q == C_LAST_WAIT)  state_d = S_ERR;
      end
      S_WB: begin
        retired_d = retired_q + 32'd1;
        state_d   = haltReq ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        if (start) state_d = S_FETCH;
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      load_q    <= 1'b0;
      store_q   <= 1'b0;
      wen_q     <= 1'b0;
      waitCnt_q <= 8'd0;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      load_q    <= load_d;
      store_q   <= store_d;
      wen_q     <= wen_d;
      waitCnt_q <= waitCnt_d;
      retired_q <= retired_d;
    end
  end

  // Moore outputs decoded only from registered state and latched class bits
  always_comb begin
    irWEn    = 1'b0;
    pcWEn    = 1'b0;
    regsWEn  = 1'b0;
    ramReq   = 1'b0;
    ramWrite = 1'b0;
    busy     = 1'b0;
    halted   = 1'b0;
    busErr   = 1'b0;
    case (state_q)
      S_FETCH:  begin irWEn = 1'b1; busy = 1'b1; end
      S_DECODE: begin busy = 1'b1; end
      S_EXEC:   begin busy = 1'b1; end
      S_MEM: begin
        ramReq   = 1'b1;
        ramWrite = store_q;
        busy     = 1'b1;
      end
      S_WB: begin
        pcWEn   = 1'b1;
        regsWEn = wen_q & ~store_q;
        busy    = 1'b1;
      end
      S_HALT:   halted = 1'b1;
      S_ERR:    busErr = 1'b1;
      default:  ;
    endcase
  end

  assign state       = state_q;
  assign instRetired = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
//------------------------------------------------------------------------------
// tb_cpu_sequencer
// Directed self-checking bench for cpu_sequencer (MEM_TIMEOUT = 15).
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, haltReq, isLoad, isStore, regsWEnDec, memReady;
  logic        irWEn, pcWEn, regsWEn, ramReq, ramWrite, busy, halted, busErr;
  logic [2:0]  state;
  logic [31:0] instRetired;
  logic [10:0] obs;

  int n_cmp  = 0;
  int n_fail = 0;

  // {state, irWEn, pcWEn, regsWEn, ramReq, ramWrite, busy, halted, busErr}
  localparam logic [10:0] V_IDLE  = 11'b000_00000_000;
  localparam logic [10:0] V_FETCH = 11'b001_10000_100;
  localparam logic [10:0] V_DEC   = 11'b010_00000_100;
  localparam logic [10:0] V_EXEC  = 11'b011_00000_100;
  localparam logic [10:0] V_MEMLD = 11'b100_00010_100;
  localparam logic [10:0] V_MEMST = 11'b100_00011_100;
  localparam logic [10:0] V_WBW   = 11'b101_01100_100;
  localparam logic [10:0] V_WBNW  = 11'b101_01000_100;
  localparam logic [10:0] V_HALT  = 11'b110_00000_010;
  localparam logic [10:0] V_ERR   = 11'b111_00000_001;

  cpu_sequencer #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .haltReq(haltReq),
    .isLoad(isLoad), .isStore(isStore), .regsWEnDec(regsWEnDec),
    .memReady(memReady), .irWEn(irWEn), .pcWEn(pcWEn), .regsWEn(regsWEn),
    .ramReq(ramReq), .ramWrite(ramWrite), .state(state), .busy(busy),
    .halted(halted), .busErr(busErr), .instRetired(instRetired)
  );

  assign obs = {state, irWEn, pcWEn, regsWEn, ramReq, ramWrite, busy, halted, busErr};

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; haltReq = 1'b0; isLoad = 1'b0;
    isStore = 1'b0; regsWEnDec = 1'b0; memReady = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; haltReq = 1'b1; isLoad = 1'b1;
    isStore = 1'b0; regsWEnDec = 1'b1; memReady = 1'b1;
    step(); step();
    n_cmp++; if (obs !== V_IDLE) begin n_fail++; $display("FAIL reset_outs: got %b want %b", obs, V_IDLE); end
    n_cmp++; if (instRetired !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0", instRetired); end
    rst_n = 1'b1; start = 1'b0; haltReq = 1'b0;
    step();
    n_cmp++; if (obs !== V_IDLE) begin n_fail++; $display("FAIL reset_idle_hold: got %b want %b", obs, V_IDLE); end
  endtask

  task automatic test_alu();
    logic [10:0] exp_v [5] = '{V_FETCH, V_DEC, V_EXEC, V_WBW, V_FETCH};
    do_reset();
    regsWEnDec = 1'b1; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) start = 1'b0;
      n_cmp++; if (obs !== exp_v[i]) begin n_fail++; $display("FAIL alu_c%0d: got %b want %b", i, obs, exp_v[i]); end
    end
    n_cmp++; if (instRetired !== 32'd1) begin n_fail++; $display("FAIL alu_retired: got %0d want 1", instRetired); end
  endtask

  task automatic test_load();
    logic [10:0] exp_v [9] = '{V_FETCH, V_DEC, V_EXEC, V_MEMLD, V_MEMLD,
                               V_MEMLD, V_MEMLD, V_WBW, V_FETCH};
    do_reset();
    isLoad = 1'b1; regsWEnDec = 1'b1; start = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      if (i == 0) start = 1'b0;
      // Class bits were latched leaving DECODE; removing them proves the latch.
      if (i == 2) begin isLoad = 1'b0; regsWEnDec = 1'b0; end
      if (i == 6) memReady = 1'b1;
      n_cmp++; if (obs !== exp_v[i]) begin n_fail++; $display("FAIL load_c%0d: got %b want %b", i, obs, exp_v[i]); end
      if (i == 7) begin
        n_cmp++; if (instRetired !== 32'd0) begin n_fail++; $display("FAIL load_cnt_wb: got %0d want 0", instRetired); end
      end
    end
    n_cmp++; if (instRetired !== 32'd1) begin n_fail++; $display("FAIL load_retired: got %0d want 1", instRetired); end
  endtask

  task automatic test_store();
    logic [10:0] exp_v [6] = '{V_FETCH, V_DEC, V_EXEC, V_MEMST, V_WBNW, V_FETCH};
    do_reset();
    isStore = 1'b1; regsWEnDec = 1'b1; memReady = 1'b1; start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 0) start = 1'b0;
      n_cmp++; if (obs !== exp_v[i]) begin n_fail++; $display("FAIL store_c%0d: got %b want %b", i, obs, exp_v[i]); end
    end
    n_cmp++; if (instRetired !== 32'd1) begin n_fail++; $display("FAIL store_retired: got %0d want 1", instRetired); end
  endtask

  task automatic test_timeout();
    logic [10:0] e;
    do_reset();
    isLoad = 1'b1; regsWEnDec = 1'b1; start = 1'b1;
    for (int i = 0; i < 19; i++) begin
      step();
      if (i == 0) start = 1'b0;
      e = (i == 0) ? V_FETCH : (i == 1) ? V_DEC : (i == 2) ? V_EXEC :
          (i < 18) ? V_MEMLD : V_ERR;
      n_cmp++; if (obs !== e) begin n_fail++; $display("FAIL timeout_c%0d: got %b want %b", i, obs, e); end
    end
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (obs !== V_ERR) begin n_fail++; $display("FAIL err_sticky_c%0d: got %b want %b", i, obs, V_ERR); end
    end
    n_cmp++; if (instRetired !== 32'd0) begin n_fail++; $display("FAIL err_cnt: got %0d want 0", instRetired); end
    start = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp++; if (obs !== V_IDLE) begin n_fail++; $display("FAIL err_reset: got %b want %b", obs, V_IDLE); end
  endtask

  task automatic test_mem_boundary();
    logic [10:0] e;
    do_reset();
    isLoad = 1'b1; regsWEnDec = 1'b1; start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 0) start = 1'b0;
      if (i == 17) memReady = 1'b1;
      e = (i == 0) ? V_FETCH : (i == 1) ? V_DEC : (i == 2) ? V_EXEC :
          (i < 18) ? V_MEMLD : (i == 18) ? V_WBW : V_FETCH;
      n_cmp++; if (obs !== e) begin n_fail++; $display("FAIL bound_c%0d: got %b want %b", i, obs, e); end
    end
    n_cmp++; if (instRetired !== 32'd1) begin n_fail++; $display("FAIL bound_retired: got %0d want 1", instRetired); end
  endtask

  task automatic test_halt();
    logic [10:0] exp_v [5] = '{V_FETCH, V_DEC, V_EXEC, V_WBNW, V_HALT};
    do_reset();
    haltReq = 1'b1;
    step(); step();
    n_cmp++; if (obs !== V_IDLE) begin n_fail++; $display("FAIL halt_idle_ignore: got %b want %b", obs, V_IDLE); end
    haltReq = 1'b0; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) start = 1'b0;
      if (i == 2) haltReq = 1'b1;
      n_cmp++; if (obs !== exp_v[i]) begin n_fail++; $display("FAIL halt_c%0d: got %b want %b", i, obs, exp_v[i]); end
    end
    step();
    n_cmp++; if (obs !== V_HALT) begin n_fail++; $display("FAIL halt_hold: got %b want %b", obs, V_HALT); end
    start = 1'b1;
    step();
    start = 1'b0; haltReq = 1'b0;
    n_cmp++; if (obs !== V_FETCH) begin n_fail++; $display("FAIL halt_restart: got %b want %b", obs, V_FETCH); end
  endtask

  task automatic test_wrap();
    logic [10:0] exp_v [5] = '{V_FETCH, V_DEC, V_EXEC, V_WBW, V_FETCH};
    do_reset();
    force dut.retired_q = 32'hFFFF_FFFF;
    step();
    release dut.retired_q;
    step();
    n_cmp++; if (instRetired !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_preload: got %h want ffffffff", instRetired); end
    regsWEnDec = 1'b1; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) start = 1'b0;
      n_cmp++; if (obs !== exp_v[i]) begin n_fail++; $display("FAIL wrap_c%0d: got %b want %b", i, obs, exp_v[i]); end
    end
    n_cmp++; if (instRetired !== 32'd0) begin n_fail++; $display("FAIL wrap_cnt: got %h want 0", instRetired); end
  endtask

  task automatic test_reset_mid_mem();
    int pc_seen = 0;
    do_reset();
    isLoad = 1'b1; regsWEnDec = 1'b1; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) start = 1'b0;
    end
    n_cmp++; if (obs !== V_MEMLD) begin n_fail++; $display("FAIL rmem_pre: got %b want %b", obs, V_MEMLD); end
    rst_n = 1'b0; memReady = 1'b1;
    step();
    rst_n = 1'b1;
    n_cmp++; if (obs !== V_IDLE) begin n_fail++; $display("FAIL rmem_idle: got %b want %b", obs, V_IDLE); end
    for (int i = 0; i < 4; i++) begin
      step();
      if (pcWEn || regsWEn) pc_seen++;
    end
    n_cmp++; if (pc_seen !== 0) begin n_fail++; $display("FAIL rmem_no_wb: got %0d strobes want 0", pc_seen); end
    n_cmp++; if (instRetired !== 32'd0) begin n_fail++; $display("FAIL rmem_cnt: got %0d want 0", instRetired); end
  endtask

  task automatic test_illegal_class();
    logic [10:0] exp_v [3] = '{V_FETCH, V_DEC, V_ERR};
    do_reset();
    isLoad = 1'b1; isStore = 1'b1; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 0) start = 1'b0;
      n_cmp++; if (obs !== exp_v[i]) begin n_fail++; $display("FAIL illegal_c%0d: got %b want %b", i, obs, exp_v[i]); end
    end
  endtask

  // Main sequence
  initial begin
    rst_n = 1'b0; start = 1'b0; haltReq = 1'b0; isLoad = 1'b0;
    isStore = 1'b0; regsWEnDec = 1'b0; memReady = 1'b0;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_timeout();
    test_mem_boundary();
    test_halt();
    test_wrap();
    test_reset_mid_mem();
    test_illegal_class();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
